// File: rtl/cic_interpolator.sv
// cic_interpolator: 5-stage CIC interpolator with runtime ratio, output shift and saturation.
// Define CIC_INTERP_HOLD_EN for sample-and-hold insertion instead of zero-stuffing.
module cic_interpolator #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter int ACC_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 interp_ratio,
    input  logic [6:0]                  out_shift,
    input  logic signed [IN_WIDTH-1:0]  d_in,
    output logic                        d_req,
    output logic                        d_clk,
    output logic signed [OUT_WIDTH-1:0] d_out
);
    localparam int N = 5;
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ~SAT_HI;

    logic [15:0] count, reff;
    logic signed [ACC_WIDTH-1:0] din_ext, u, shifted;
    logic signed [ACC_WIDTH-1:0] dly [N];
    logic signed [ACC_WIDTH-1:0] comb [N];
    logic signed [ACC_WIDTH-1:0] integ [N];

    assign reff    = (interp_ratio == 16'd0) ? 16'd1 : interp_ratio;
    assign d_req   = (count == 16'd0) && !rst;
    assign din_ext = ACC_WIDTH'(d_in);

    // >= lets a ratio decrease wrap at once instead of running to 65535
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            d_clk <= 1'b0;
        end else begin
            count <= (count >= reff - 16'd1) ? '0 : count + 16'd1;
            d_clk <= (reff == 16'd1) || (count < (reff >> 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly  <= '{default: '0};
            comb <= '{default: '0};
        end else if (d_req) begin
            dly[0]  <= din_ext;
            comb[0] <= din_ext - dly[0];
            for (int k = 1; k < N; k++) begin
                dly[k]  <= comb[k-1];
                comb[k] <= comb[k-1] - dly[k];
            end
        end
    end

`ifdef CIC_INTERP_HOLD_EN
    assign u = comb[N-1];
`else
    // each new comb output enters the integrators exactly once
    logic v_int;
    always_ff @(posedge clk) v_int <= rst ? 1'b0 : d_req;
    assign u = v_int ? comb[N-1] : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            integ <= '{default: '0};
        end else begin
            integ[0] <= integ[0] + u;
            for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    assign shifted = (32'(out_shift) >= ACC_WIDTH) ? $signed({ACC_WIDTH{integ[N-1][ACC_WIDTH-1]}})
                                                   : integ[N-1] >>> out_shift;

    always_ff @(posedge clk) begin
        if (rst) d_out <= '0;
        else d_out <= (shifted > SAT_HI) ? SAT_HI[OUT_WIDTH-1:0] :
                      (shifted < SAT_LO) ? SAT_LO[OUT_WIDTH-1:0] : shifted[OUT_WIDTH-1:0];
    end
endmodule
